// File: rtl/xc_malu_pkg.sv
// Shared types and constants for the MALU multiply-accumulate stage.
// Optional build macro XC_MALU_MUL_RADIX4_EN selects two multiplier bits per step.
package xc_malu_pkg;

    localparam int XLEN_DEFAULT = 32;

`ifdef XC_MALU_MUL_RADIX4_EN
    localparam int MUL_BITS_PER_STEP = 2;
`else
    localparam int MUL_BITS_PER_STEP = 1;
`endif

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    function automatic int mul_latency(input int xlen);
        return xlen / MUL_BITS_PER_STEP;
    endfunction

    localparam int MUL_LATENCY = mul_latency(XLEN_DEFAULT);

endpackage

// File: rtl/xc_malu_mul_step.sv
// One shift-add step: adds a<<(count+i) for every set multiplier bit i.
// Combinational, no latency; no handshake.
// Backpressure: none, the caller owns all state.
module xc_malu_mul_step #(
    parameter int XLEN = 32,
    parameter int BITS = 1,
    parameter int CW   = $clog2(XLEN)
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   a,
    input  logic [BITS-1:0]   mul_bits,
    input  logic [CW-1:0]     count,
    output logic [2*XLEN-1:0] acc_nxt
);

    logic [2*XLEN-1:0] a_ext;

    assign a_ext = {{XLEN{1'b0}}, a};

    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < BITS; i++) begin
            if (mul_bits[i]) begin
                acc_nxt = acc_nxt + (a_ext << (int'(count) + i));
            end
        end
    end

endmodule

// File: rtl/xc_malu_mul.sv
// Iterative unsigned rs1*rs2+rs3 for MALU long arithmetic (XC_MALU_MUL_RADIX4_EN: 2 bits/step).
// Latency: XLEN (or XLEN/2) cycles from accept edge to out_valid; one op in flight.
// Backpressure: result held in DONE until out_ready; in_ready low in BUSY/DONE.
module xc_malu_mul
    import xc_malu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rs3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd_hi,
    output logic [XLEN-1:0] rd_lo
);

    localparam int CW   = $clog2(XLEN);
    localparam int STEP = MUL_BITS_PER_STEP;
    localparam logic [CW-1:0] COUNT_LAST = CW'(XLEN - STEP);

    mul_state_t        state_q, state_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] res_q, res_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] step_acc;
    logic [STEP-1:0]   mul_bits;

`ifdef XC_MALU_MUL_RADIX4_EN
    logic [CW-1:0] count_p1;
    assign count_p1 = count_q + CW'(1);
    assign mul_bits = {b_q[count_p1], b_q[count_q]};
`else
    assign mul_bits = b_q[count_q];
`endif

    xc_malu_mul_step #(
        .XLEN (XLEN),
        .BITS (STEP),
        .CW   (CW)
    ) u_step (
        .acc      (acc_q),
        .a        (a_q),
        .mul_bits (mul_bits),
        .count    (count_q),
        .acc_nxt  (step_acc)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        count_d = count_q;
        case (state_q)
            MUL_IDLE: begin
                if (in_valid) begin
                    a_d     = rs1;
                    b_d     = rs2;
                    acc_d   = {{XLEN{1'b0}}, rs3};
                    count_d = '0;
                    state_d = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                acc_d   = step_acc;
                count_d = count_q + CW'(STEP);
                if (count_q == COUNT_LAST) begin
                    // result copied out so rd_* keep the last value after leaving DONE
                    res_d   = step_acc;
                    count_d = '0;
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                if (out_ready) begin
                    state_d = MUL_IDLE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
        if (flush) begin
            state_d = MUL_IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MUL_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == MUL_IDLE);
    assign out_valid = (state_q == MUL_DONE);
    assign rd_hi     = res_q[2*XLEN-1:XLEN];
    assign rd_lo     = res_q[XLEN-1:0];

endmodule

// File: tb/tb_xc_malu_mul.sv
// Directed and random checks of xc_malu_mul against a 64-bit arithmetic model.
module tb_xc_malu_mul;
    import xc_malu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rs1 = '0, rs2 = '0, rs3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] rd_hi, rd_lo;

    int passed = 0;
    int total  = 0;

    xc_malu_mul #(.XLEN(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs3       (rs3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_hi     (rd_hi),
        .rd_lo     (rd_lo)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
        return 64'(x) * 64'(y) + 64'(z);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Presents operands for one edge, then scrambles them to show they are ignored.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        @(negedge clock);
        rs1 = x; rs2 = y; rs3 = z; in_valid = 1'b1;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        rs1 = $urandom; rs2 = $urandom; rs3 = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    logic [63:0] exp;
    logic [31:0] x, y, z;
    int          lat;
    int          seen;
    bit          checked, consumed;
    int          cyc;

    initial begin
        // Reset
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_rd", {rd_hi, rd_lo}, 64'd0);

        // Small operands
        out_ready = 1'b1;
        issue(32'd3, 32'd5, 32'd7);
        wait_done(lat);
        check("small_latency", 64'(lat), 64'(MUL_LATENCY));
        check("small_rd", {rd_hi, rd_lo}, 64'h16);
        check("small_in_ready_in_done", 64'(in_ready), 64'd0);
        @(posedge clock); #1;
        check("small_consume_in_ready", 64'(in_ready), 64'd1);
        check("small_consume_out_valid", 64'(out_valid), 64'd0);

        // Maximum operands
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat);
        check("max_latency", 64'(lat), 64'(MUL_LATENCY));
        check("max_rd_model", {rd_hi, rd_lo}, model(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF));
        check("max_rd_const", {rd_hi, rd_lo}, 64'hFFFFFFFF_00000000);
        @(posedge clock); #1;

        // Backpressure
        out_ready = 1'b0;
        issue(32'h80000000, 32'd2, 32'd0);
        wait_done(lat);
        check("bp_latency", 64'(lat), 64'(MUL_LATENCY));
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("bp_rd_held", {rd_hi, rd_lo}, 64'h00000001_00000000);
            check("bp_vld_rdy", {62'd0, out_valid, in_ready}, 64'b10);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Flush at BUSY cycle 10
        issue($urandom, $urandom, $urandom);
        repeat (9) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        check("flush_no_out_valid", 64'(seen), 64'd0);

        // Flush in IDLE with in_valid does not accept
        @(negedge clock);
        in_valid = 1'b1; flush = 1'b1; rs1 = 32'd9; rs2 = 32'd9; rs3 = 32'd9;
        @(posedge clock); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", 64'(in_ready), 64'd1);

        issue(32'd0, 32'd0, 32'h1234);
        wait_done(lat);
        check("post_flush_latency", 64'(lat), 64'(MUL_LATENCY));
        check("post_flush_rd", {rd_hi, rd_lo}, 64'h1234);
        @(posedge clock); #1;

        // Flush in DONE drops the result without handshake; rd holds
        out_ready = 1'b0;
        x = $urandom; y = $urandom; z = $urandom;
        issue(x, y, z);
        wait_done(lat);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_done_vld_rdy", {62'd0, out_valid, in_ready}, 64'b01);
        check("flush_done_rd_hold", {rd_hi, rd_lo}, model(x, y, z));

        // Reset in DONE
        issue($urandom, $urandom, $urandom);
        wait_done(lat);
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("reset_done_out_valid", 64'(out_valid), 64'd0);
        check("reset_done_rd", {rd_hi, rd_lo}, 64'd0);
        check("reset_done_in_ready", 64'(in_ready), 64'd1);

        // Random back-to-back with random out_ready
        for (int n = 0; n < 1000; n++) begin
            x = $urandom; y = $urandom; z = $urandom;
            case ($urandom_range(0, 3))
                0: x = 32'hFFFFFFFF;
                1: y = 32'd0;
                default: ;
            endcase
            exp = model(x, y, z);
            issue(x, y, z);
            checked = 1'b0; consumed = 1'b0; cyc = 0;
            while (!consumed && cyc < 200) begin
                @(negedge clock);
                out_ready = $urandom_range(0, 1);
                if (out_valid && !checked) begin
                    check("rand_rd", {rd_hi, rd_lo}, exp);
                    checked = 1'b1;
                end
                if (out_valid && out_ready) consumed = 1'b1;
                @(posedge clock);
                cyc++;
            end
            if (!consumed) check("rand_timeout", 64'(cyc), 64'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
